as2650_mem_arbiter: RTL

AS2650_MEM_ARBITER -- requirements
Module: as2650_mem_arbiter

---
 rtl/as2650_mem_arbiter_if.sv | 50 +++++
 rtl/as2650_mem_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/as2650_mem_arbiter_if.sv
// Bus bundle for the 2650 memory arbiter: CPU side, Wishbone slave side and
// the external asynchronous SRAM pins.
//
// Handshake: a CPU request is cpu_req held high until the one-cycle cpu_ack
// pulse; a Wishbone request is wbs_cyc_i & wbs_stb_i held high until the
// one-cycle wbs_ack_o pulse. Read data is valid only in the ack cycle, and an
// ack arriving after a request was withdrawn is ignored by the requester.
interface as2650_mem_arbiter_if #(
   parameter int ADDR_W = 15
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic [7:0]        cpu_rdata;
   logic              cpu_ack;

   logic              wbs_cyc_i;
   logic              wbs_stb_i;
   logic              wbs_we_i;
   logic [31:0]       wbs_adr_i;
   logic [31:0]       wbs_dat_i;
   logic [31:0]       wbs_dat_o;
   logic              wbs_ack_o;

   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_dout;
   logic [7:0]        mem_din;
   logic              mem_dout_en;
   logic              mem_oe_n;
   logic              mem_we_n;

   // Arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
      input  mem_din,
      output cpu_rdata, cpu_ack, wbs_dat_o, wbs_ack_o,
      output mem_addr, mem_dout, mem_dout_en, mem_oe_n, mem_we_n
   );

   // Requester / memory side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
      output mem_din,
      input  cpu_rdata, cpu_ack, wbs_dat_o, wbs_ack_o,
      input  mem_addr, mem_dout, mem_dout_en, mem_oe_n, mem_we_n
   );
endinterface

// File: rtl/as2650_mem_arbiter.sv
// Shares one external byte-wide SRAM between the 2650 CPU and a Wishbone
// slave port. Each access is IDLE (grant) -> ACCESS (WAIT_STATES+1 cycles)
// -> DONE (ack pulse). Contested grants alternate, CPU first after reset.
module as2650_mem_arbiter #(
   parameter int WAIT_STATES = 2,
   parameter int ADDR_W      = 15
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   as2650_mem_arbiter_if.slave  bus,
   output logic [1:0]           dbg_state_o
);
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        rdata_q, rdata_d;
   logic              owner_wb_q, owner_wb_d;
   logic              last_wb_q, last_wb_d;
   logic              wb_valid;
   logic              grant_wb;
   logic              unused_bits;

   assign wb_valid = bus.wbs_cyc_i & bus.wbs_stb_i;

   // Upper address and data bits of the Wishbone port have no meaning here.
   assign unused_bits = ^{bus.wbs_adr_i[31:ADDR_W], bus.wbs_dat_i[31:8]};

   // Arbitration, access register loading and next-state selection
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      owner_wb_d = owner_wb_q;
      last_wb_d  = last_wb_q;
      grant_wb   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.cpu_req || wb_valid) begin
               // WB wins when alone, or when contested and the CPU won last time
               grant_wb   = wb_valid && (!bus.cpu_req || !last_wb_q);
               if (bus.cpu_req && wb_valid) begin
                  last_wb_d = grant_wb;
               end
               owner_wb_d = grant_wb;
               addr_d     = grant_wb ? bus.wbs_adr_i[ADDR_W-1:0] : bus.cpu_addr;
               we_d       = grant_wb ? bus.wbs_we_i : bus.cpu_we;
               wdata_d    = grant_wb ? bus.wbs_dat_i[7:0] : bus.cpu_wdata;
               cnt_d      = WAIT_INIT;
               state_d    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               // Last access cycle: read data is sampled here, then ack
               if (!we_q) begin
                  rdata_d = bus.mem_din;
               end
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and access registers; reset aborts any access in flight
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= 8'h00;
         rdata_q    <= 8'h00;
         owner_wb_q <= 1'b0;
         last_wb_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         owner_wb_q <= owner_wb_d;
         last_wb_q  <= last_wb_d;
      end
   end

   // Memory strobes and acks decoded from state; the final write cycle holds data with WE released
   always_comb begin
      bus.mem_oe_n    = 1'b1;
      bus.mem_we_n    = 1'b1;
      bus.mem_dout_en = 1'b0;
      bus.cpu_ack     = 1'b0;
      bus.wbs_ack_o   = 1'b0;
      bus.wbs_dat_o   = 32'h0;
      if (state_q == ST_ACCESS) begin
         if (we_q) begin
            bus.mem_dout_en = 1'b1;
            bus.mem_we_n    = (cnt_q == 4'd0);
         end else begin
            bus.mem_oe_n = 1'b0;
         end
      end
      if (state_q == ST_DONE) begin
         if (owner_wb_q) begin
            bus.wbs_ack_o = 1'b1;
            bus.wbs_dat_o = {24'h0, rdata_q};
         end else begin
            bus.cpu_ack = 1'b1;
         end
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_dout  = wdata_q;
   assign bus.cpu_rdata = rdata_q;
   assign dbg_state_o   = state_q;

endmodule
